// File: rtl/xbar_initiator_pkg.sv
// Shared crossbar definitions: slave select codes, CLINT window and initiator FSM states.
package ysyx_22050499_xbar_pkg;

  localparam logic [3:0] SEL_NONE  = 4'b0000;
  localparam logic [3:0] SEL_CLINT = 4'b0001;
  localparam logic [3:0] SEL_SRAM  = 4'b0010;
  localparam logic [3:0] SEL_UART  = 4'b0100;

  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_SIZE = 32'h0001_0000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/xbar_initiator_addr_decode.sv
// Combinational address decoder: maps a byte address onto the one-hot slave select.
module xbar_addr_decode #(
  parameter logic [31:0] BASE = ysyx_22050499_xbar_pkg::CLINT_BASE,
  parameter logic [31:0] SIZE = ysyx_22050499_xbar_pkg::CLINT_SIZE
) (
  input  logic [31:0] addr,
  output logic [3:0]  sel,
  output logic        hit
);
  import ysyx_22050499_xbar_pkg::*;

  logic [31:0] offset;

  // Unsigned offset compare: addresses below BASE wrap to large values and miss.
  assign offset = addr - BASE;
  assign hit    = (offset < SIZE);
  assign sel    = hit ? SEL_CLINT : SEL_NONE;

endmodule

// File: rtl/xbar_initiator.sv
// Crossbar initiator: takes one CPU request at a time, drives the slave mux and returns one response.
module xbar_initiator #(
  parameter logic [31:0] CLINT_BASE = ysyx_22050499_xbar_pkg::CLINT_BASE,
  parameter logic [31:0] CLINT_SIZE = ysyx_22050499_xbar_pkg::CLINT_SIZE,
  parameter int          TIMEOUT    = 255,
  parameter int          TO_W       = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  xbar_decode,
  output logic [31:0] raddr,
  output logic        ren,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wen,
  input  logic        slave_arready,
  input  logic        slave_rvalid,
  input  logic [31:0] slave_rdata,
  input  logic        slave_awready,
  input  logic        slave_wready
);
  import ysyx_22050499_xbar_pkg::*;

  state_t            state, state_n;
  logic [TO_W-1:0]   cnt, cnt_n;
  logic              aw_done, aw_n, w_done, w_n;
  logic              req_ready_n, rsp_valid_n, rsp_err_n, ren_n, wen_n;
  logic [31:0]       rsp_rdata_n, raddr_n, waddr_n, wdata_n;
  logic [3:0]        xbar_decode_n, wstrb_n;
  logic [3:0]        dec_sel;
  logic              dec_hit;
  logic              timed_out;
  logic              enter_resp, resp_err;
  logic [31:0]       resp_data;

  xbar_addr_decode #(
    .BASE (CLINT_BASE),
    .SIZE (CLINT_SIZE)
  ) u_decode (
    .addr (req_addr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  assign timed_out = (cnt == TO_W'(TIMEOUT - 1));

  // Every output is registered; this block computes their next values alongside the state.
  always_comb begin
    state_n       = state;
    cnt_n         = '0;
    aw_n          = aw_done;
    w_n           = w_done;
    req_ready_n   = req_ready;
    rsp_valid_n   = rsp_valid;
    rsp_err_n     = rsp_err;
    rsp_rdata_n   = rsp_rdata;
    xbar_decode_n = xbar_decode;
    raddr_n       = raddr;
    ren_n         = ren;
    waddr_n       = waddr;
    wdata_n       = wdata;
    wstrb_n       = wstrb;
    wen_n         = wen;
    enter_resp    = 1'b0;
    resp_err      = 1'b0;
    resp_data     = '0;

    case (state)
      IDLE: begin
        aw_n = 1'b0;
        w_n  = 1'b0;
        if (req_valid) begin
          req_ready_n = 1'b0;
          if (!dec_hit) begin
            enter_resp = 1'b1;
            resp_err   = 1'b1;
          end else if (req_we) begin
            state_n       = WR;
            xbar_decode_n = dec_sel;
            wen_n         = 1'b1;
            waddr_n       = req_addr;
            wdata_n       = req_wdata;
            wstrb_n       = req_wstrb;
          end else begin
            state_n       = RD_ADDR;
            xbar_decode_n = dec_sel;
            ren_n         = 1'b1;
            raddr_n       = req_addr;
          end
        end
      end
      RD_ADDR: begin
        cnt_n = cnt + 1'b1;
        if (slave_arready && slave_rvalid) begin
          enter_resp = 1'b1;
          resp_data  = slave_rdata;
        end else if (slave_arready) begin
          state_n = RD_DATA;
          ren_n   = 1'b0;
          cnt_n   = '0;
        end else if (timed_out) begin
          enter_resp = 1'b1;
          resp_err   = 1'b1;
        end
      end
      RD_DATA: begin
        cnt_n = cnt + 1'b1;
        if (slave_rvalid) begin
          enter_resp = 1'b1;
          resp_data  = slave_rdata;
        end else if (timed_out) begin
          enter_resp = 1'b1;
          resp_err   = 1'b1;
        end
      end
      WR: begin
        cnt_n = cnt + 1'b1;
        aw_n  = aw_done | slave_awready;
        w_n   = w_done | slave_wready;
        if (aw_n && w_n) begin
          enter_resp = 1'b1;
        end else if (timed_out) begin
          enter_resp = 1'b1;
          resp_err   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
          rsp_err_n   = 1'b0;
          rsp_rdata_n = '0;
          req_ready_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Entering RESP always withdraws all slave traffic before the response is shown.
    if (enter_resp) begin
      state_n       = RESP;
      cnt_n         = '0;
      aw_n          = 1'b0;
      w_n           = 1'b0;
      rsp_valid_n   = 1'b1;
      rsp_err_n     = resp_err;
      rsp_rdata_n   = resp_err ? 32'h0 : resp_data;
      xbar_decode_n = SEL_NONE;
      ren_n         = 1'b0;
      wen_n         = 1'b0;
      raddr_n       = '0;
      waddr_n       = '0;
      wdata_n       = '0;
      wstrb_n       = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      xbar_decode <= SEL_NONE;
      raddr       <= '0;
      ren         <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
      wstrb       <= '0;
      wen         <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      aw_done     <= aw_n;
      w_done      <= w_n;
      req_ready   <= req_ready_n;
      rsp_valid   <= rsp_valid_n;
      rsp_err     <= rsp_err_n;
      rsp_rdata   <= rsp_rdata_n;
      xbar_decode <= xbar_decode_n;
      raddr       <= raddr_n;
      ren         <= ren_n;
      waddr       <= waddr_n;
      wdata       <= wdata_n;
      wstrb       <= wstrb_n;
      wen         <= wen_n;
    end
  end

endmodule
